// File: rtl/seq_cla_subtractor_if.sv
// seq_cla_subtractor_if: start/busy/done handshake and result bus of the sequential subtractor
interface seq_cla_subtractor_if #(parameter int WIDTH = 32);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             zero;
  logic             negative;
  logic             overflow;
  modport master (output start, a, b, input busy, done, diff, borrow, zero, negative, overflow);
  modport slave  (input start, a, b, output busy, done, diff, borrow, zero, negative, overflow);
endinterface

// File: rtl/seq_cla_subtractor.sv
// seq_cla_subtractor: a - b as a + ~b + 1, one SLICE-bit lookahead slice per clock, LSB slice first
module seq_cla_subtractor #(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  seq_cla_subtractor_if.slave bus
);
  localparam int N  = WIDTH / SLICE;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           r_state;
  logic [IW-1:0]    r_idx;
  logic             r_carry;
  logic [WIDTH-1:0] r_op_a, r_op_b, r_work, r_diff;
  logic             r_busy, r_done, r_borrow, r_zero, r_negative, r_overflow;
  logic [SLICE-1:0] w_sa, w_sb, w_g, w_p, w_sum;
  logic [SLICE:0]   w_c;
  logic             w_t, w_cout, w_last;
  logic [WIDTH-1:0] w_next;
  assign w_sa   = r_op_a[int'(r_idx)*SLICE +: SLICE];
  assign w_sb   = r_op_b[int'(r_idx)*SLICE +: SLICE];
  assign w_g    = w_sa & w_sb;
  assign w_p    = w_sa ^ w_sb;
  assign w_sum  = w_p ^ w_c[SLICE-1:0];
  assign w_cout = w_c[SLICE];
  assign w_last = r_idx == IW'(N-1);
  // Each carry is a flat sum of generate terms gated by the propagates above them, no ripple.
  always_comb begin
    w_c    = '0;
    w_t    = 1'b0;
    w_c[0] = r_carry;
    for (int i = 1; i <= SLICE; i++) begin
      w_t = r_carry;
      for (int j = 0; j < i; j++) w_t = w_t & w_p[j];
      w_c[i] = w_t;
      for (int j = 0; j < i; j++) begin
        w_t = w_g[j];
        for (int k = j + 1; k < i; k++) w_t = w_t & w_p[k];
        w_c[i] = w_c[i] | w_t;
      end
    end
  end
  always_comb begin
    w_next = r_work;
    w_next[int'(r_idx)*SLICE +: SLICE] = w_sum;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_carry    <= 1'b0;
      r_op_a     <= '0;
      r_op_b     <= '0;
      r_work     <= '0;
      r_diff     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_borrow   <= 1'b0;
      r_zero     <= 1'b0;
      r_negative <= 1'b0;
      r_overflow <= 1'b0;
    end else if (r_state == IDLE) begin
      if (bus.start) begin
        r_op_a  <= bus.a;
        r_op_b  <= ~bus.b;
        r_carry <= 1'b1;
        r_idx   <= '0;
        r_state <= RUN;
        r_busy  <= 1'b1;
      end
    end else if (r_state == RUN) begin
      r_work  <= w_next;
      r_carry <= w_cout;
      r_idx   <= w_last ? '0 : r_idx + 1'b1;
      if (w_last) begin
        r_state    <= DONE;
        r_busy     <= 1'b0;
        r_done     <= 1'b1;
        r_diff     <= w_next;
        r_borrow   <= ~w_cout;
        r_zero     <= w_next == '0;
        r_negative <= w_next[WIDTH-1];
        r_overflow <= (r_op_a[WIDTH-1] != ~r_op_b[WIDTH-1]) && (w_next[WIDTH-1] != r_op_a[WIDTH-1]);
      end
    end else begin
      r_state <= IDLE;
      r_done  <= 1'b0;
    end
  end
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.diff     = r_diff;
  assign bus.borrow   = r_borrow;
  assign bus.zero     = r_zero;
  assign bus.negative = r_negative;
  assign bus.overflow = r_overflow;
endmodule
